uart_tx_arbiter: RTL and testbench

Packet-oriented round-robin arbiter that shares the single UART transmit path among several byte-stream requesters. Each requester presents bytes with a valid/ready handshake and a last flag. The arbiter grants one requester at a time for a whole packet and forwards its bytes into the UART TX FIFO write port (`data_in`/`wren`), honouring `tx_full`. Burst-limit and stall-timeout guards ensure that one requester cannot monopolise the transmitter.

---
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams and UART TX FIFO write port shared by the arbiter.
// slave is the arbiter's view; master is the view of the requesters and FIFO.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           uart_data;
  logic                 uart_wren;
  logic                 uart_tx_full;

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_full,
    output req_ready, uart_data, uart_wren
  );

  modport master (
    output req_valid, req_data, req_last, uart_tx_full,
    input  req_ready, uart_data, uart_wren
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one UART TX FIFO from NUM_REQ
// byte-stream requesters. A grant is held for a whole packet unless the
// burst limit or the stall timeout forces an early release.
//
//   state | meaning
//   IDLE  | no owner; pick next requester round-robin after last_g
//   XFER  | requester g owns the FIFO write port
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 16,
  parameter int STALL_TIMEOUT = 1023
) (
  input  logic               CLK,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               truncated,
  output logic               timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t       state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] last_g_q, last_g_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          trunc_d, tmo_d;

  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic [IW-1:0] cand;

  logic          cur_valid, cur_last, hs;
  logic [7:0]    cur_data;

  logic [NUM_REQ-1:0] ready_o;
  logic               wren_o;
  logic [7:0]         data_o;

  // Round-robin search: first valid requester starting just after last_g.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = last_g_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cand == IW'(NUM_REQ - 1)) cand = '0;
      else                          cand = cand + 1'b1;
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Current owner's request lines.
  always_comb begin
    cur_valid = bus.req_valid[g_q];
    cur_last  = bus.req_last[g_q];
    cur_data  = bus.req_data[{g_q, 3'b000} +: 8];
  end

  // Next-state, counters and handshake outputs.
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    last_g_d = last_g_q;
    burst_d  = burst_q;
    stall_d  = stall_q;
    trunc_d  = 1'b0;
    tmo_d    = 1'b0;
    ready_o  = '0;
    wren_o   = 1'b0;
    data_o   = '0;
    hs       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = XFER;
          g_d     = pick_idx;
          burst_d = '0;
          stall_d = '0;
        end
      end
      XFER: begin
        ready_o[g_q] = ~bus.uart_tx_full;
        hs           = cur_valid & ~bus.uart_tx_full;
        wren_o       = hs;
        data_o       = cur_data;
        if (hs && cur_last) begin
          state_d  = IDLE;
          last_g_d = g_q;
        end else if (hs && (burst_q == BW'(MAX_BURST - 1))) begin
          state_d  = IDLE;
          last_g_d = g_q;
          trunc_d  = 1'b1;
        end else if (!cur_valid && (stall_q == SW'(STALL_TIMEOUT - 1))) begin
          state_d  = IDLE;
          last_g_d = g_q;
          tmo_d    = 1'b1;
        end else begin
          if (hs) burst_d = burst_q + 1'b1;
          // A full FIFO with valid data waiting is back-pressure, not a stall.
          if (cur_valid) stall_d = '0;
          else           stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant bookkeeping and release pulses.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      g_q       <= '0;
      last_g_q  <= IW'(NUM_REQ - 1);
      burst_q   <= '0;
      stall_q   <= '0;
      truncated <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      last_g_q  <= last_g_d;
      burst_q   <= burst_d;
      stall_q   <= stall_d;
      truncated <= trunc_d;
      timeout   <= tmo_d;
    end
  end

  assign bus.req_ready = ready_o;
  assign bus.uart_wren = wren_o;
  assign bus.uart_data = data_o;
  assign busy          = (state_q == XFER);
  assign grant         = (state_q == XFER) ? (NUM_REQ'(1) << g_q) : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: 4 requesters, burst limit 16, stall
// timeout 8. Requesters are modelled as per-port byte lists that advance on
// each accepted byte; outputs are checked at the falling clock edge.
module tb_uart_tx_arbiter;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0] grant;
  logic busy, truncated, timeout;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(16), .STALL_TIMEOUT(8)) dut (
    .CLK(clk), .rst_n(rst_n), .bus(bus),
    .grant(grant), .busy(busy), .truncated(truncated), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [8:0] mem [NR][32];
  int head [NR];
  int tail [NR];
  logic full_next;
  logic tmo_seen;
  logic [7:0] wr_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    mem[r][tail[r]] = {l, d};
    tail[r]++;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic drive();
    logic [NR-1:0] v, l;
    logic [8*NR-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NR; i++) begin
      if (head[i] < tail[i]) begin
        v[i] = 1'b1;
        d[8*i +: 8] = mem[i][head[i]][7:0];
        l[i] = mem[i][head[i]][8];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
  endtask

  // Called at a falling edge; advances one clock and returns at the next falling edge.
  task automatic step();
    logic [NR-1:0] hsm;
    hsm = bus.req_valid & bus.req_ready;
    if (bus.uart_wren) wr_log.push_back(bus.uart_data);
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (hsm[i]) head[i]++;
    bus.uart_tx_full = full_next;
    drive();
    @(negedge clk);
    if (timeout) tmo_seen = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    full_next = 1'b0;
    bus.uart_tx_full = 1'b0;
    drive();
    wr_log.delete();
    tmo_seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] fair_exp [11];
    fair_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000,
                 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010};

    // reset state
    rst_n = 1'b0;
    clear_reqs();
    full_next = 1'b0;
    bus.uart_tx_full = 1'b0;
    tmo_seen = 1'b0;
    drive();
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wren", bus.uart_wren, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_trunc", truncated, 0);
    chk("rst_tmo", timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic packet on req0
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
    drive();
    step();
    chk("basic_grant", grant, 4'b0001);
    chk("basic_busy1", busy, 1);
    chk("basic_wren1", bus.uart_wren, 1);
    chk("basic_data1", bus.uart_data, 8'h41);
    step();
    chk("basic_wren2", bus.uart_wren, 1);
    chk("basic_data2", bus.uart_data, 8'h42);
    step();
    chk("basic_wren3", bus.uart_wren, 1);
    chk("basic_data3", bus.uart_data, 8'h43);
    step();
    chk("basic_busy4", busy, 0);
    chk("basic_wren4", bus.uart_wren, 0);

    // fairness: all requesters with back-to-back 1-byte packets
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 3; k++) push(i, 8'hA0 + 8'(16 * i + k), 1'b1);
    drive();
    for (int c = 0; c < 11; c++) begin
      step();
      chk($sformatf("fair_grant_c%0d", c + 1), grant, fair_exp[c]);
      chk($sformatf("fair_wren_c%0d", c + 1), bus.uart_wren, (c % 2 == 0) ? 1 : 0);
    end
    chk("fair_data_c11", bus.uart_data, 8'hB1);

    // back-pressure in the middle of a 6-byte packet on req1
    do_reset();
    for (int k = 0; k < 6; k++) push(1, 8'h61 + 8'(k), (k == 5));
    drive();
    step();
    chk("bp_data1", bus.uart_data, 8'h61);
    step();
    chk("bp_data2", bus.uart_data, 8'h62);
    full_next = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_ready_%0d", k), bus.req_ready, 0);
      chk($sformatf("bp_wren_%0d", k), bus.uart_wren, 0);
      chk($sformatf("bp_busy_%0d", k), busy, 1);
      if (k == 4) full_next = 1'b0;
      step();
    end
    for (int k = 2; k < 6; k++) begin
      chk($sformatf("bp_data_%0d", k + 1), bus.uart_data, 8'h61 + 8'(k));
      step();
    end
    chk("bp_busy_end", busy, 0);
    chk("bp_count", wr_log.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < wr_log.size()) chk($sformatf("bp_log_%0d", k), wr_log[k], 8'h61 + 8'(k));
    chk("bp_no_timeout", tmo_seen, 0);

    // burst limit: req2 streams 20 bytes without last, req3 pending
    do_reset();
    for (int k = 0; k < 20; k++) push(2, 8'hB0 + 8'(k), 1'b0);
    push(3, 8'hD0, 1'b0); push(3, 8'hD1, 1'b1);
    drive();
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("burst_grant_%0d", k), grant, 4'b0100);
      chk($sformatf("burst_wren_%0d", k), bus.uart_wren, 1);
      chk($sformatf("burst_data_%0d", k), bus.uart_data, 8'hB0 + 8'(k));
    end
    step();
    chk("burst_trunc", truncated, 1);
    chk("burst_idle", busy, 0);
    step();
    chk("burst_trunc_off", truncated, 0);
    chk("burst_g3", grant, 4'b1000);
    chk("burst_d0", bus.uart_data, 8'hD0);
    step();
    chk("burst_d1", bus.uart_data, 8'hD1);
    step();
    chk("burst_gap", grant, 0);
    step();
    chk("burst_resume_g", grant, 4'b0100);
    chk("burst_resume_d", bus.uart_data, 8'hC0);

    // stall timeout on req1, req2 waiting
    do_reset();
    push(1, 8'h5A, 1'b0);
    push(2, 8'h77, 1'b1);
    drive();
    step();
    chk("stall_grant", grant, 4'b0010);
    chk("stall_data", bus.uart_data, 8'h5A);
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("stall_hold_%0d", k), grant, 4'b0010);
      chk($sformatf("stall_wren_%0d", k), bus.uart_wren, 0);
      chk($sformatf("stall_tmo_%0d", k), timeout, 0);
    end
    step();
    chk("stall_tmo", timeout, 1);
    chk("stall_idle", busy, 0);
    chk("stall_wren_idle", bus.uart_wren, 0);
    step();
    chk("stall_tmo_off", timeout, 0);
    chk("stall_next_g", grant, 4'b0100);
    chk("stall_next_d", bus.uart_data, 8'h77);

    // reset in the middle of req0's packet
    do_reset();
    push(0, 8'h31, 1'b0); push(0, 8'h32, 1'b0); push(0, 8'h33, 1'b1);
    drive();
    step();
    step();
    chk("mid_data2", bus.uart_data, 8'h32);
    chk("mid_wren2", bus.uart_wren, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_wren_rst", bus.uart_wren, 0);
    chk("mid_grant_rst", grant, 0);
    chk("mid_busy_rst", busy, 0);
    clear_reqs();
    push(0, 8'h01, 1'b1);
    push(1, 8'h02, 1'b1);
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mid_after_g", grant, 4'b0001);
    chk("mid_after_d", bus.uart_data, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
